echo_ind_serializer: RTL and testbench
======================================

# echo_ind_serializer

Downstream stage of the echo responder. It accepts `ind_echo` indication calls of 32-bit payloads and buffers them in a small FIFO. It serializes each one into a two-word portal message (header, then payload) on a 32-bit word stream toward the host indication channel. This decouples the responder's rule from host back-pressure.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `METHOD_ID`, default 8'h00: indication method number placed in header bits [31:24].

Ports:
- `CLK` in, 1 bit: clock.
- `nRST` in, 1 bit: synchronous, active-low reset.
- `ind_echo__RDY` out, 1 bit: the block can accept an indication.
- `ind_echo__ENA` in, 1 bit: indication call strobe.
- `ind_echo_v` in, 32 bits: indication payload.
- `out_word__ENA` out, 1 bit: output word valid.
- `out_word__RDY` in, 1 bit: downstream accepts a word.
- `out_word_v` out, 32 bits: output word.
- `out_word_last` out, 1 bit: the current word is the last word of its message.
- `msg_count` out, 16 bits: messages fully sent since reset. Wraps modulo 2^16.

## Operation
- Enqueue fires when `ind_echo__ENA && ind_echo__RDY`.
  - `ind_echo__RDY = nRST && (count != DEPTH)`.
  - `ind_echo__ENA` while `ind_echo__RDY` is 0 is ignored: no state change.
- FIFO storage:
  - Circular buffer with read pointer, write pointer and occupancy count `0..DEPTH`.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
- Word transfer fires when `out_word__ENA && out_word__RDY`.
- Serializer FSM states: IDLE, HDR, PAY.
  - IDLE: `out_word__ENA` = 0. Go to HDR when `count != 0`, sampled at the clock edge.
  - HDR: `out_word__ENA` = 1, `out_word_last` = 0.
    - `out_word_v = {METHOD_ID, seq[7:0], 16'd2}`.
    - On transfer, go to PAY.
  - PAY: `out_word__ENA` = 1, `out_word_last` = 1, `out_word_v` = FIFO head entry.
    - On transfer: dequeue, `seq <= seq+1` (wraps at 256), `msg_count <= msg_count+1`.
    - Next state is HDR if the FIFO occupancy after this edge is nonzero, otherwise IDLE.
- Occupancy with simultaneous enqueue and dequeue in one cycle: count is unchanged and both pointers advance.
  - Permitted at any count except DEPTH, where RDY is 0.
  - An enqueue in the same cycle as the final PAY dequeue keeps the FIFO nonempty, so the next state is HDR.
- Output hold rule: while `out_word__ENA && !out_word__RDY`, `out_word_v` and `out_word_last` hold stable. The state does not change.
- FIFO entries are not cleared on reset. Only the pointers and count are reset.

## Timing
- Reset (`nRST` low at an edge) sets: state IDLE, count 0, pointers 0, `seq` 0, `msg_count` 0.
- Output values while `nRST` is low and on the first cycle after reset:
  - `ind_echo__RDY` = 0 while `nRST` is low, then 1 after reset.
  - `out_word__ENA` = 0, `out_word_last` = 0.
  - `out_word_v` = 0 in IDLE.
- Reset mid-message aborts the message. No further words of it are emitted, and buffered entries are discarded.
- Latency, with `out_word__RDY` held at 1:
  - Enqueue accepted at edge t: the header is presented in the cycle after edge t+1.
  - The header transfers at edge t+2 and the payload at edge t+3.
- Sustained throughput: 1 message per 2 cycles, with no IDLE bubble while the FIFO stays nonempty.
- `ind_echo__RDY` depends only on the count register and `nRST`. There is no combinational path from `out_word__RDY`.
- `out_word__ENA`, `out_word_v` and `out_word_last` are decoded from registered state and the FIFO head only.

## Test plan
- Single message: with RDY=1, enqueue 32'hDEADBEEF.
  - Words are 32'h0000_0002 (last=0) then 32'hDEADBEEF (last=1).
  - `msg_count` becomes 1; the next header carries seq=1.
- Fill: hold `out_word__RDY`=0 and enqueue 5 values back-to-back.
  - `ind_echo__RDY` drops after the 4th; the 5th is dropped.
  - Releasing RDY yields 8 words (4 headers and 4 payloads in order) with seq 0..3, no gaps between messages, and `msg_count`=4.
- Stall: deassert `out_word__RDY` for 3 cycles in HDR and 3 in PAY.
  - Words hold stable and no duplicates appear; `msg_count` increments once.
- Simultaneous enqueue and dequeue: count=3, with enqueue and the PAY transfer on the same edge.
  - Count stays 3, the next state is HDR, and ordering is preserved across pointer wrap over 10 messages.
- Seq wrap: send 257 messages. Header 256 has seq 8'h00 (32'h0000_0002 with METHOD_ID=0), and `msg_count`=257.
- Reset mid-PAY with 2 entries queued:
  - `out_word__ENA` is 0 on the next cycle and `ind_echo__RDY` is 1 after reset.
  - A new enqueue produces a header with seq 0, and `msg_count` restarts at 0.

Source files
------------

// File: rtl/echo_ind_serializer_if.sv
// Handshake bundle between the echo responder, the indication serializer and
// the host word stream. The serializer takes the slave view.
interface echo_ind_serializer_if;
  logic        ind_echo__RDY;
  logic        ind_echo__ENA;
  logic [31:0] ind_echo_v;
  logic        out_word__ENA;
  logic        out_word__RDY;
  logic [31:0] out_word_v;
  logic        out_word_last;
  logic [15:0] msg_count;

  modport slave (
    output ind_echo__RDY,
    input  ind_echo__ENA,
    input  ind_echo_v,
    output out_word__ENA,
    input  out_word__RDY,
    output out_word_v,
    output out_word_last,
    output msg_count
  );

  modport master (
    input  ind_echo__RDY,
    output ind_echo__ENA,
    output ind_echo_v,
    input  out_word__ENA,
    output out_word__RDY,
    input  out_word_v,
    input  out_word_last,
    input  msg_count
  );
endinterface

// File: rtl/echo_ind_serializer.sv
// Buffers ind_echo payloads in a small FIFO and emits each one as a two-word
// portal message (header, payload) toward the host indication channel.
module echo_ind_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  METHOD_ID = 8'h00
) (
  input  logic                  CLK,
  input  logic                  nRST,
  echo_ind_serializer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         seq_q, seq_d;
  logic [15:0]        msg_count_q, msg_count_d;
  logic [31:0]        mem_q [DEPTH];

  logic rdy, enq, out_ena, xfer, deq;

  // Ready depends only on the count register, never on downstream ready.
  assign rdy     = nRST && (count_q != CNT_W'(DEPTH));
  assign enq     = bus.ind_echo__ENA && rdy;
  assign out_ena = (state_q != IDLE);
  assign xfer    = out_ena && bus.out_word__RDY;
  assign deq     = (state_q == PAY) && xfer;

  assign bus.ind_echo__RDY = rdy;
  assign bus.out_word__ENA = out_ena;
  assign bus.out_word_last = (state_q == PAY);
  assign bus.msg_count     = msg_count_q;

  always_comb begin
    bus.out_word_v = 32'd0;
    case (state_q)
      HDR:     bus.out_word_v = {METHOD_ID, seq_q, 16'd2};
      PAY:     bus.out_word_v = mem_q[rd_ptr_q];
      default: bus.out_word_v = 32'd0;
    endcase
  end

  // NOTE: every next-state variable gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    seq_d       = seq_q;
    msg_count_d = msg_count_q;
    count_d     = count_q + CNT_W'(enq) - CNT_W'(deq);

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      seq_d       = seq_q + 8'd1;
      msg_count_d = msg_count_q + 16'd1;
    end

    case (state_q)
      IDLE:    if (count_q != '0) state_d = HDR;
      HDR:     if (xfer) state_d = PAY;
      PAY:     if (xfer) state_d = (count_d != '0) ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      seq_q       <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      seq_q       <= seq_d;
      msg_count_q <= msg_count_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q] <= bus.ind_echo_v;
  end

endmodule

// File: tb/tb_echo_ind_serializer.sv
// Self-checking bench for echo_ind_serializer: scoreboard of expected words,
// occupancy model for ready, hold checks during stalls, directed corner cases.
module tb_echo_ind_serializer;

  localparam int DEPTH = 4;

  logic clk;
  logic nRST;

  echo_ind_serializer_if bus ();

  echo_ind_serializer #(.DEPTH(DEPTH), .METHOD_ID(8'h00)) dut (
    .CLK  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] payload;
    int          stall_hdr;
    int          stall_pay;
    logic [15:0] exp_msg_count;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples just after each falling edge, i.e. the values the DUT
  // sees at the next rising edge.
  initial begin : monitor
    logic [7:0]  m_seq;
    int          m_count;
    logic        prev_stall;
    logic [31:0] prev_v;
    logic        prev_last;
    exp_t        e;
    m_seq = 8'd0; m_count = 0; prev_stall = 1'b0; prev_v = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!nRST) begin
        sb.delete();
        m_seq = 8'd0;
        m_count = 0;
        prev_stall = 1'b0;
      end else begin
        check("ind_rdy_model", 32'(bus.ind_echo__RDY), 32'(m_count != DEPTH));
        if (prev_stall) begin
          check("hold_ena", 32'(bus.out_word__ENA), 32'd1);
          check("hold_word", bus.out_word_v, prev_v);
          check("hold_last", 32'(bus.out_word_last), 32'(prev_last));
        end
        if (bus.out_word__ENA && bus.out_word__RDY) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none at %0t", bus.out_word_v, $time);
          end else begin
            e = sb.pop_front();
            check("word", bus.out_word_v, e.word);
            check("last", 32'(bus.out_word_last), 32'(e.last));
            if (e.last) m_count--;
          end
        end
        if (bus.ind_echo__ENA && bus.ind_echo__RDY) begin
          sb.push_back('{word: {8'h00, m_seq, 16'd2}, last: 1'b0});
          sb.push_back('{word: bus.ind_echo_v, last: 1'b1});
          m_seq = m_seq + 8'd1;
          m_count++;
        end
        prev_stall = bus.out_word__ENA && !bus.out_word__RDY;
        prev_v     = bus.out_word_v;
        prev_last  = bus.out_word_last;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    nRST = 1'b0;
    bus.ind_echo__ENA = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic drain();
    bus.out_word__RDY = 1'b1;
    bus.ind_echo__ENA = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0 && !bus.out_word__ENA) break;
      tick();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(bus.out_word__ENA), 32'd0);
  endtask

  task automatic send_one(input vec_t v);
    bit seen;
    bus.out_word__RDY = 1'b0;
    bus.ind_echo__ENA = 1'b1;
    bus.ind_echo_v    = v.payload;
    tick();
    bus.ind_echo__ENA = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_word__ENA) begin seen = 1'b1; break; end
      tick();
    end
    check("hdr_appears", 32'(seen), 32'd1);
    repeat (v.stall_hdr) tick();
    bus.out_word__RDY = 1'b1;
    tick();
    bus.out_word__RDY = 1'b0;
    check("pay_presented", 32'(bus.out_word_last), 32'd1);
    repeat (v.stall_pay) tick();
    bus.out_word__RDY = 1'b1;
    tick();
    check("vec_msg_count", 32'(bus.msg_count), 32'(v.exp_msg_count));
    check("vec_idle", 32'(bus.out_word__ENA), 32'd0);
  endtask

  initial begin : driver
    vec_t vecs[5];
    int   sent;

    vecs[0] = '{payload: 32'hCAFE_F00D, stall_hdr: 0, stall_pay: 0, exp_msg_count: 16'd2};
    vecs[1] = '{payload: 32'h1234_5678, stall_hdr: 3, stall_pay: 3, exp_msg_count: 16'd3};
    vecs[2] = '{payload: 32'hA5A5_A5A5, stall_hdr: 1, stall_pay: 2, exp_msg_count: 16'd4};
    vecs[3] = '{payload: 32'h0000_0000, stall_hdr: 2, stall_pay: 0, exp_msg_count: 16'd5};
    vecs[4] = '{payload: 32'hFFFF_FFFF, stall_hdr: 0, stall_pay: 4, exp_msg_count: 16'd6};

    nRST = 1'b0;
    bus.ind_echo__ENA = 1'b0;
    bus.ind_echo_v    = '0;
    bus.out_word__RDY = 1'b1;
    tick();
    tick();
    check("rst_in_rdy_low", 32'(bus.ind_echo__RDY), 32'd0);
    check("rst_out_ena", 32'(bus.out_word__ENA), 32'd0);
    check("rst_out_last", 32'(bus.out_word_last), 32'd0);
    nRST = 1'b1;
    tick();
    check("post_rst_rdy", 32'(bus.ind_echo__RDY), 32'd1);
    check("post_rst_ena", 32'(bus.out_word__ENA), 32'd0);
    check("post_rst_word", bus.out_word_v, 32'd0);
    check("post_rst_msg_count", 32'(bus.msg_count), 32'd0);

    // Single message and latency: enqueue at edge t, header after t+1.
    bus.ind_echo__ENA = 1'b1;
    bus.ind_echo_v    = 32'hDEAD_BEEF;
    tick();
    bus.ind_echo__ENA = 1'b0;
    check("lat_idle", 32'(bus.out_word__ENA), 32'd0);
    tick();
    check("lat_hdr_ena", 32'(bus.out_word__ENA), 32'd1);
    check("lat_hdr_word", bus.out_word_v, 32'h0000_0002);
    check("lat_hdr_last", 32'(bus.out_word_last), 32'd0);
    tick();
    check("lat_pay_word", bus.out_word_v, 32'hDEAD_BEEF);
    check("lat_pay_last", 32'(bus.out_word_last), 32'd1);
    tick();
    check("single_msg_count", 32'(bus.msg_count), 32'd1);
    check("single_idle", 32'(bus.out_word__ENA), 32'd0);

    // Table of single messages with header/payload stalls (seq 1..5).
    for (int i = 0; i < 5; i++) send_one(vecs[i]);
    drain();

    // Fill: four accepted, fifth dropped, then eight gap-free words.
    reset_dut();
    bus.out_word__RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("fill_rdy_low", 32'(bus.ind_echo__RDY), 32'd0);
      bus.ind_echo__ENA = 1'b1;
      bus.ind_echo_v    = 32'h1000_0000 + 32'(i);
      tick();
    end
    bus.ind_echo__ENA = 1'b0;
    bus.out_word__RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_no_gap", 32'(bus.out_word__ENA), 32'd1);
      tick();
    end
    check("fill_msg_count", 32'(bus.msg_count), 32'd4);
    check("fill_idle", 32'(bus.out_word__ENA), 32'd0);

    // Simultaneous enqueue and final PAY dequeue at count 3, then wrap.
    reset_dut();
    bus.out_word__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ind_echo__ENA = 1'b1;
      bus.ind_echo_v    = 32'h2000_0000 + 32'(i);
      tick();
    end
    bus.ind_echo__ENA = 1'b0;
    bus.out_word__RDY = 1'b1;
    tick();
    check("simul_in_pay", 32'(bus.out_word_last), 32'd1);
    bus.ind_echo__ENA = 1'b1;
    bus.ind_echo_v    = 32'h2000_0003;
    tick();
    bus.ind_echo__ENA = 1'b0;
    check("simul_next_hdr_ena", 32'(bus.out_word__ENA), 32'd1);
    check("simul_next_hdr_last", 32'(bus.out_word_last), 32'd0);
    check("simul_rdy", 32'(bus.ind_echo__RDY), 32'd1);
    sent = 0;
    for (int c = 0; c < 100 && sent < 9; c++) begin
      if (bus.out_word__ENA && bus.out_word_last) begin
        bus.ind_echo__ENA = 1'b1;
        bus.ind_echo_v    = $urandom;
        sent++;
      end else begin
        bus.ind_echo__ENA = 1'b0;
      end
      tick();
    end
    drain();
    check("simul_msg_count", 32'(bus.msg_count), 32'd13);

    // Sequence number wraps after 256 messages.
    reset_dut();
    bus.out_word__RDY = 1'b1;
    sent = 0;
    for (int c = 0; c < 2000 && sent < 257; c++) begin
      if (bus.ind_echo__RDY) begin
        bus.ind_echo__ENA = 1'b1;
        bus.ind_echo_v    = $urandom;
        sent++;
      end else begin
        bus.ind_echo__ENA = 1'b0;
      end
      tick();
    end
    drain();
    check("wrap_msg_count", 32'(bus.msg_count), 32'd257);

    // Reset in PAY with entries queued aborts the message.
    reset_dut();
    bus.out_word__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ind_echo__ENA = 1'b1;
      bus.ind_echo_v    = 32'h3000_0000 + 32'(i);
      tick();
    end
    bus.ind_echo__ENA = 1'b0;
    bus.out_word__RDY = 1'b1;
    tick();
    bus.out_word__RDY = 1'b0;
    check("abort_in_pay", 32'(bus.out_word_last), 32'd1);
    nRST = 1'b0;
    tick();
    check("abort_ena", 32'(bus.out_word__ENA), 32'd0);
    check("abort_rdy_in_reset", 32'(bus.ind_echo__RDY), 32'd0);
    nRST = 1'b1;
    bus.out_word__RDY = 1'b1;
    tick();
    check("abort_rdy_after", 32'(bus.ind_echo__RDY), 32'd1);
    check("abort_ena_after", 32'(bus.out_word__ENA), 32'd0);
    check("abort_msg_count", 32'(bus.msg_count), 32'd0);
    bus.ind_echo__ENA = 1'b1;
    bus.ind_echo_v    = 32'h0BAD_CAFE;
    tick();
    bus.ind_echo__ENA = 1'b0;
    tick();
    check("abort_new_hdr", bus.out_word_v, 32'h0000_0002);
    drain();
    check("abort_new_msg_count", 32'(bus.msg_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
